// File: rtl/as_hazard_unit.sv
// Hazard unit: forwarding, load-use/branch control, memory-wait FSM with timeout.
// Optional performance counters when AS_HAZ_PERF_EN is defined.
module as_hazard_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memrd_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwr_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwr_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  input  logic              branch_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              hold_mem_o,
  output logic              timeout_o,
  input  logic              perf_clr_i,
  output logic [CNT_W-1:0]  fwd_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned WCW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TO_VAL = WCW'(TIMEOUT);

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           timeout_q, timeout_d;
  logic           hold;
  logic           load_use;

  always_comb begin
    forward_a_o = 2'd0;
    forward_b_o = 2'd0;
    if (mem_regwr_i && mem_rd_i != '0 && mem_rd_i == ex_rs1_i)
      forward_a_o = 2'd2;
    else if (wb_regwr_i && wb_rd_i != '0 && wb_rd_i == ex_rs1_i)
      forward_a_o = 2'd1;
    if (mem_regwr_i && mem_rd_i != '0 && mem_rd_i == ex_rs2_i)
      forward_b_o = 2'd2;
    else if (wb_regwr_i && wb_rd_i != '0 && wb_rd_i == ex_rs2_i)
      forward_b_o = 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    hold      = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          hold    = 1'b1;
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          state_d = S_RUN;
        end else if (TIMEOUT != 0 && wcnt_q == TO_VAL) begin
          // Give up on the access; the flag stays until reset.
          state_d   = S_RUN;
          timeout_d = 1'b1;
        end else begin
          hold   = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign load_use = ex_memrd_i && ex_rd_i != '0 &&
                    (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);

  always_comb begin
    hold_mem_o = hold && !rst_i;
    flush_id_o = !rst_i && !hold && branch_i;
    flush_ex_o = !rst_i && !hold && (branch_i || load_use);
    stall_o    = !rst_i && (hold || (!branch_i && load_use));
  end

  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef AS_HAZ_PERF_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       nfwd;
  logic [CNT_W:0]   fsum;

  always_comb begin
    nfwd = {1'b0, forward_a_o != 2'd0} +
           {1'b0, forward_b_o != 2'd0};
    fsum = {1'b0, fwd_cnt_q} + (CNT_W+1)'(nfwd);
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (perf_clr_i) begin
      fwd_cnt_d   = '0;
      stall_cnt_d = '0;
    end else if (!hold_mem_o) begin
      fwd_cnt_d = fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
      if (stall_o && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign fwd_cnt_o       = '0;
  assign stall_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_as_hazard_unit.sv
// Scoreboard bench for as_hazard_unit (TIMEOUT=4, CNT_W=4).
// Expected output vectors are queued at drive time and popped at sample time.
module tb_as_hazard_unit;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] id_rs1_i, id_rs2_i, ex_rs1_i, ex_rs2_i, ex_rd_i;
  logic          ex_memrd_i;
  logic [AW-1:0] mem_rd_i, wb_rd_i;
  logic          mem_regwr_i, wb_regwr_i;
  logic          mem_req_i, mem_ack_i, branch_i, perf_clr_i;
  logic [1:0]    forward_a_o, forward_b_o;
  logic          stall_o, flush_id_o, flush_ex_o, hold_mem_o, timeout_o;
  logic [CW-1:0] fwd_cnt_o, stall_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [7:0] cnt_q[$];
  logic [8:0] obs, e;
  logic [7:0] ce;

  assign obs = {forward_a_o, forward_b_o, stall_o, flush_id_o,
                flush_ex_o, hold_mem_o, timeout_o};

  as_hazard_unit #(.REG_AW(AW), .CNT_W(CW), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_memrd_i(ex_memrd_i),
    .mem_rd_i(mem_rd_i), .mem_regwr_i(mem_regwr_i),
    .wb_rd_i(wb_rd_i), .wb_regwr_i(wb_regwr_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .branch_i(branch_i),
    .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
    .stall_o(stall_o), .flush_id_o(flush_id_o),
    .flush_ex_o(flush_ex_o), .hold_mem_o(hold_mem_o),
    .timeout_o(timeout_o), .perf_clr_i(perf_clr_i),
    .fwd_cnt_o(fwd_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [8:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic st, input logic fid,
                                    input logic fex, input logic hd,
                                    input logic to);
    return {fa, fb, st, fid, fex, hd, to};
  endfunction

  task automatic idle();
    id_rs1_i = '0; id_rs2_i = '0; ex_rs1_i = '0; ex_rs2_i = '0;
    ex_rd_i = '0; ex_memrd_i = 1'b0; mem_rd_i = '0; mem_regwr_i = 1'b0;
    wb_rd_i = '0; wb_regwr_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
    branch_i = 1'b0; perf_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    @(negedge clk_i);
    mem_req_i = 1'b1; branch_i = 1'b1;
    ex_memrd_i = 1'b1; ex_rd_i = 5'd3; id_rs1_i = 5'd3;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", obs, e);
    end
    checks++;
    if (fwd_cnt_o !== 4'd0 || stall_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", fwd_cnt_o, stall_cnt_o);
    end
    @(negedge clk_i);
    idle();
    rst_i = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs, e);
    end
  endtask

  task automatic test_forward();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_i);
      idle();
      case (s)
        0: begin
          mem_rd_i = 5'd7; mem_regwr_i = 1'b1; ex_rs1_i = 5'd7; ex_rs2_i = 5'd6;
          exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0));
        end
        1: begin
          wb_rd_i = 5'd7; wb_regwr_i = 1'b1; mem_rd_i = 5'd8; mem_regwr_i = 1'b1;
          ex_rs1_i = 5'd9; ex_rs2_i = 5'd7;
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        end
        2: begin
          wb_rd_i = 5'd7; wb_regwr_i = 1'b1; mem_rd_i = 5'd7; mem_regwr_i = 1'b1;
          ex_rs1_i = 5'd9; ex_rs2_i = 5'd7;
          exp_q.push_back(mk(0, 2, 0, 0, 0, 0, 0));
        end
        3: begin
          wb_regwr_i = 1'b1; mem_regwr_i = 1'b1;
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        default: begin
          wb_rd_i = 5'd12; wb_regwr_i = 1'b1; mem_rd_i = 5'd12;
          ex_rs1_i = 5'd12; ex_rs2_i = 5'd12;
          exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        end
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL forward step %0d got %b exp %b", s, obs, e);
      end
    end
  endtask

  task automatic test_load_use();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_i);
      idle();
      case (s)
        0: begin
          ex_memrd_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5;
          exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 0));
        end
        1: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        2: begin
          ex_memrd_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; branch_i = 1'b1;
          exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        end
        3: begin
          ex_memrd_i = 1'b1;
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        default: begin
          ex_memrd_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_rs2_i = 5'd2;
          exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 0));
        end
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_use step %0d got %b exp %b", s, obs, e);
      end
    end
  endtask

  task automatic test_mem_wait();
    for (int s = 0; s < 7; s++) begin
      @(negedge clk_i);
      idle();
      case (s)
        0: begin
          mem_req_i = 1'b1; branch_i = 1'b1;
          exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0));
        end
        1, 2: begin
          mem_req_i = 1'b1; branch_i = 1'b1;
          mem_rd_i = 5'd7; mem_regwr_i = 1'b1; ex_rs1_i = 5'd7;
          exp_q.push_back(mk(2, 0, 1, 0, 0, 1, 0));
        end
        3: begin
          mem_req_i = 1'b1; mem_ack_i = 1'b1; branch_i = 1'b1;
          exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        end
        5: begin
          mem_req_i = 1'b1; mem_ack_i = 1'b1;
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mem_wait step %0d got %b exp %b", s, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    for (int s = 0; s < 11; s++) begin
      @(negedge clk_i);
      idle();
      case (s)
        0, 1, 2, 3, 4: begin
          mem_req_i = 1'b1;
          exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0));
        end
        5: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        6: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        7, 8: begin
          mem_req_i = 1'b1;
          exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 1));
        end
        9: begin
          mem_req_i = 1'b1; branch_i = 1'b1; rst_i = 1'b1;
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        default: begin
          rst_i = 1'b0;
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout step %0d got %b exp %b", s, obs, e);
      end
    end
  endtask

  task automatic test_perf();
    int fc;
    int sc;
    @(negedge clk_i);
    idle();
    perf_clr_i = 1'b1;
    fc = 0;
    sc = 0;
    for (int s = 0; s < 28; s++) begin
      @(negedge clk_i);
      idle();
      cnt_q.push_back({4'(fc), 4'(sc)});
      if (s < 20) begin
        ex_memrd_i = 1'b1; ex_rd_i = 5'd4; id_rs1_i = 5'd4;
        sc = (sc < 15) ? sc + 1 : 15;
      end else if (s < 23) begin
        mem_rd_i = 5'd7; mem_regwr_i = 1'b1; ex_rs1_i = 5'd7; ex_rs2_i = 5'd7;
        fc = (fc + 2 > 15) ? 15 : fc + 2;
      end else if (s == 23) begin
        mem_rd_i = 5'd7; mem_regwr_i = 1'b1; ex_rs1_i = 5'd7; ex_rs2_i = 5'd7;
        mem_req_i = 1'b1;
      end else if (s == 24) begin
        mem_rd_i = 5'd7; mem_regwr_i = 1'b1; ex_rs1_i = 5'd7; ex_rs2_i = 5'd7;
        mem_req_i = 1'b1; mem_ack_i = 1'b1;
        fc = fc + 2;
      end else if (s == 25) begin
        perf_clr_i = 1'b1;
        ex_memrd_i = 1'b1; ex_rd_i = 5'd4; id_rs1_i = 5'd4;
        mem_rd_i = 5'd7; mem_regwr_i = 1'b1; ex_rs1_i = 5'd7;
        fc = 0;
        sc = 0;
      end
`ifndef AS_HAZ_PERF_EN
      fc = 0;
      sc = 0;
`endif
      #1;
      ce = cnt_q.pop_front();
      checks++;
      if ({fwd_cnt_o, stall_cnt_o} !== ce) begin
        errors++;
        $display("FAIL perf step %0d got fwd %0d stall %0d exp fwd %0d stall %0d",
                 s, fwd_cnt_o, stall_cnt_o, ce[7:4], ce[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/as_hazard_unit.md
AS_HAZARD_UNIT -- requirements
Module: as_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, 5: register-address width.
REQ-002 SHALL have parameter CNT_W, 32: performance-counter width.
REQ-003 SHALL have parameter TIMEOUT, 255: maximum data-memory wait cycles; 0 disables the timeout.
REQ-004 SHALL have port clk_i  in  1  core clock, rising edge active.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports id_rs1_i / id_rs2_i  in  REG_AW  source registers of the instruction in decode.
REQ-007 SHALL have ports ex_rs1_i / ex_rs2_i  in  REG_AW  source registers in the ID/EX register.
REQ-008 SHALL have port ex_rd_i  in  REG_AW  destination register in ID/EX.
REQ-009 SHALL have port ex_memrd_i  in  1  a load is in EX.
REQ-010 SHALL have ports mem_rd_i  in  REG_AW and mem_regwr_i  in  1  EX/MEM destination and write enable.
REQ-011 SHALL have ports wb_rd_i  in  REG_AW and wb_regwr_i  in  1  MEM/WB destination and write enable.
REQ-012 SHALL have ports mem_req_i / mem_ack_i  in  1  data-memory access in MEM / access complete.
REQ-013 SHALL have port branch_i  in  1  taken branch or jump resolved in EX.
REQ-014 SHALL have ports forward_a_o / forward_b_o  out  2  ALU operand select: 0 = register file, 1 = MEM/WB, 2 = EX/MEM.
REQ-015 SHALL have port stall_o  out  1  holds PC, IF/ID and ID/EX.
REQ-016 SHALL have ports flush_id_o / flush_ex_o  out  1  insert a bubble into IF/ID / ID/EX.
REQ-017 SHALL have port hold_mem_o  out  1  freezes EX/MEM and MEM/WB.
REQ-018 SHALL have port timeout_o  out  1  sticky memory-timeout flag.
REQ-019 SHALL have ports perf_clr_i  in  1, plus fwd_cnt_o and stall_cnt_o  out  CNT_W  performance counters.

Function
REQ-020 Forward A SHALL be 2 when mem_regwr_i=1, mem_rd_i!=0 and mem_rd_i==ex_rs1_i.
REQ-021 Otherwise, forward A SHALL be 1 when wb_regwr_i=1, wb_rd_i!=0 and wb_rd_i==ex_rs1_i; otherwise 0. Forward B SHALL follow the same rules using ex_rs2_i.
REQ-022 Forward outputs SHALL be combinational (zero latency) and SHALL remain valid during every hold.
REQ-023 The FSM SHALL have states RUN and WAIT.
REQ-024 In RUN, mem_req_i=1 with mem_ack_i=0 SHALL assert stall_o and hold_mem_o in that same cycle (Mealy output) and move to WAIT.
REQ-025 In RUN, mem_req_i=1 with mem_ack_i=1 SHALL cause no stall.
REQ-026 In WAIT, stall_o=1 and hold_mem_o=1 SHALL be asserted until the cycle in which mem_ack_i=1; in that cycle both SHALL deassert and the next state SHALL be RUN.
REQ-027 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 If TIMEOUT!=0 and the wait counter reaches TIMEOUT, the access SHALL be abandoned: holds deassert, the next state is RUN, and timeout_o is set until reset.
REQ-029 Load-use: in RUN with no memory hold, ex_memrd_i=1, ex_rd_i!=0 and ex_rd_i matching id_rs1_i or id_rs2_i SHALL assert stall_o and flush_ex_o for exactly that cycle.
REQ-030 branch_i=1 SHALL assert flush_id_o and flush_ex_o for one cycle and suppress the load-use stall.
REQ-031 Priority SHALL be memory hold > branch flush > load-use stall. While a hold is active, flush_id_o and flush_ex_o SHALL be 0, because branch_i stays held in the frozen EX.
REQ-032 Performance counters SHALL update only when hold_mem_o=0.
REQ-033 fwd_cnt_o SHALL add the count of nonzero forward selects (0, 1 or 2) each cycle; stall_cnt_o SHALL add 1 on each cycle with stall_o=1.
REQ-034 Both counters SHALL saturate at all-ones; perf_clr_i SHALL clear both synchronously and SHALL take priority over increments.

Reset
REQ-035 rst_i=1 SHALL immediately force state RUN, clear the wait counter, timeout_o and both counters, and drive stall_o, flush_id_o, flush_ex_o and hold_mem_o to 0.
REQ-036 Reset asserted during WAIT SHALL abandon the access, with no timeout flagged.

Configuration
REQ-037 With macro AS_HAZ_PERF_EN defined, the performance counters SHALL be implemented as specified.
REQ-038 Without AS_HAZ_PERF_EN, fwd_cnt_o and stall_cnt_o SHALL be constant 0, perf_clr_i SHALL be ignored, and no counter flops SHALL exist.

Verification
REQ-039 mem_rd_i=7, mem_regwr_i=1, ex_rs1_i=7, ex_rs2_i=6 -> forward_a_o=2, forward_b_o=0.
REQ-040 wb_rd_i=7, wb_regwr_i=1, mem_rd_i=8, mem_regwr_i=1, ex_rs1_i=9, ex_rs2_i=7 -> forward_a_o=0, forward_b_o=1; with mem_rd_i=7 as well -> forward_b_o=2; with rd=0 -> no forwarding.
REQ-041 ex_memrd_i=1, ex_rd_i=5, id_rs2_i=5 -> stall_o=1 and flush_ex_o=1 for 1 cycle; the same stimulus plus branch_i=1 -> flush_id_o=1, flush_ex_o=1, stall_o=0.
REQ-042 mem_req_i=1 with mem_ack_i arriving 3 cycles later -> stall_o and hold_mem_o high for exactly 3 cycles; with branch_i=1 throughout -> flush outputs 0 during the hold, then 1 for one cycle.
REQ-043 TIMEOUT=4 with mem_ack_i never asserted -> hold released after 4 WAIT cycles and timeout_o=1 until rst_i; rst_i pulsed mid-WAIT -> all outputs 0, timeout_o=0.
REQ-044 With AS_HAZ_PERF_EN and CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturated); perf_clr_i -> 0 on the next edge, even with a concurrent increment.
